// File: rtl/ram_init_loader_if.sv
// Byte-stream / SRAM-write bundle for ram_init_loader.
// The slave modport is the loader's view. The master modport is the view of
// the block that drives the byte source and observes the SRAM side.
interface ram_init_loader_if #(
  parameter int ADDR_WIDTH = 20
);
  logic                  LOAD_MEM;
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [15:0]           sram_wdata;
  logic                  sram_we;
  logic                  RAM_INIT_DONE;
  logic [ADDR_WIDTH:0]   words_written;

  modport slave (
    input  LOAD_MEM, byte_valid, byte_data,
    output byte_ready, sram_addr, sram_wdata, sram_we, RAM_INIT_DONE, words_written
  );

  modport master (
    output LOAD_MEM, byte_valid, byte_data,
    input  byte_ready, sram_addr, sram_wdata, sram_we, RAM_INIT_DONE, words_written
  );
endinterface

// File: rtl/ram_init_loader.sv
// Loads NUM_WORDS 16-bit little-endian words into the sample SRAM from a
// valid/ready byte stream. Each word is written at the next sequential
// address, starting from 0. RAM_INIT_DONE is held high once the last word
// has been written. All outputs come from registers or from the state alone,
// so there is no combinational path from byte_valid to any output.
module ram_init_loader #(
  parameter int ADDR_WIDTH   = 20,
  parameter int NUM_WORDS    = 4096,
  parameter int WRITE_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  ram_init_loader_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOW   = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // The write counter counts down from WRITE_CYCLES-1 to 0.
  localparam int WCNT_W = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
  localparam logic [WCNT_W-1:0]     WCNT_LOAD = WCNT_W'(WRITE_CYCLES - 1);
  localparam logic [WCNT_W-1:0]     WCNT_ONE  = WCNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;

  // Next-state logic. The DONE test comes before the address increment,
  // so the address never goes past the last word.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wcnt_d  = wcnt_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        addr_d  = '0;
        count_d = '0;
        if (bus.LOAD_MEM) begin
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (bus.byte_valid) begin
          wdata_d[7:0] = bus.byte_data;
          state_d      = S_HIGH;
        end
      end
      S_HIGH: begin
        if (bus.byte_valid) begin
          wdata_d[15:8] = bus.byte_data;
          wcnt_d        = WCNT_LOAD;
          state_d       = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wcnt_q == '0) begin
          count_d = count_q + CNT_ONE;
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADDR_ONE;
            state_d = S_LOW;
          end
        end else begin
          wcnt_d = wcnt_q - WCNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers. A synchronous reset abandons any word in progress.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wcnt_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wcnt_q  <= wcnt_d;
      count_q <= count_d;
    end
  end

  // Drive the outputs from the registers and from a decode of the state.
  always_comb begin
    bus.byte_ready    = (state_q == S_LOW) || (state_q == S_HIGH);
    bus.sram_we       = (state_q == S_WRITE);
    bus.RAM_INIT_DONE = (state_q == S_DONE);
    bus.sram_addr     = addr_q;
    bus.sram_wdata    = wdata_q;
    bus.words_written = count_q;
  end

endmodule

// File: tb/tb_ram_init_loader.sv
// Self-checking bench for ram_init_loader. Two instances are used: one with
// 4 words and 2 write cycles, and one with 1 word and 1 write cycle. A select
// bit routes the shared stimulus to one instance at a time. A negedge monitor
// turns the SRAM port activity into a list of writes (address, data, length).
// That list is compared with the writes expected from the bytes sent.
module tb_ram_init_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic tb_load = 1'b0;
  logic tb_valid = 1'b0;
  logic [7:0] tb_data = 8'h00;

  always #5 clk = ~clk;

  ram_init_loader_if #(.ADDR_WIDTH(20)) a_if ();
  ram_init_loader_if #(.ADDR_WIDTH(20)) b_if ();

  ram_init_loader #(.ADDR_WIDTH(20), .NUM_WORDS(4), .WRITE_CYCLES(2)) dut_a (
    .Clk(clk), .Reset(rst), .bus(a_if)
  );
  ram_init_loader #(.ADDR_WIDTH(20), .NUM_WORDS(1), .WRITE_CYCLES(1)) dut_b (
    .Clk(clk), .Reset(rst), .bus(b_if)
  );

  assign a_if.LOAD_MEM   = ~sel & tb_load;
  assign a_if.byte_valid = ~sel & tb_valid;
  assign a_if.byte_data  = tb_data;
  assign b_if.LOAD_MEM   = sel & tb_load;
  assign b_if.byte_valid = sel & tb_valid;
  assign b_if.byte_data  = tb_data;

  logic        v_ready, v_we, v_done;
  logic [19:0] v_addr;
  logic [15:0] v_wdata;
  logic [20:0] v_ww;
  assign v_ready = sel ? b_if.byte_ready    : a_if.byte_ready;
  assign v_we    = sel ? b_if.sram_we       : a_if.sram_we;
  assign v_done  = sel ? b_if.RAM_INIT_DONE : a_if.RAM_INIT_DONE;
  assign v_addr  = sel ? b_if.sram_addr     : a_if.sram_addr;
  assign v_wdata = sel ? b_if.sram_wdata    : a_if.sram_wdata;
  assign v_ww    = sel ? b_if.words_written : a_if.words_written;

  int n_checks = 0;
  int n_fail = 0;

  // Monitor state
  int          cyc_cnt = 0;
  int          first_ready = -1;
  int          done_cyc = -1;
  int          max_addr = 0;
  int          run_len = 0;
  int          stable_err = 0;
  logic [19:0] cur_addr = '0;
  logic [15:0] cur_data = '0;
  int          wr_addr_q[$];
  int          wr_data_q[$];
  int          wr_len_q[$];
  logic [7:0]  acc_q[$];
  logic [7:0]  src_q[$];

  always @(negedge clk) begin
    cyc_cnt = cyc_cnt + 1;
    if (v_ready && first_ready < 0) first_ready = cyc_cnt;
    if (v_done && done_cyc < 0) done_cyc = cyc_cnt;
    if (int'(v_addr) > max_addr) max_addr = int'(v_addr);
    if (v_ready && tb_valid) acc_q.push_back(tb_data);
    if (v_we) begin
      if (run_len == 0) begin
        cur_addr = v_addr;
        cur_data = v_wdata;
      end else if (v_addr !== cur_addr || v_wdata !== cur_data) begin
        stable_err = stable_err + 1;
      end
      run_len = run_len + 1;
    end else if (run_len != 0) begin
      wr_addr_q.push_back(int'(cur_addr));
      wr_data_q.push_back(int'(cur_data));
      wr_len_q.push_back(run_len);
      run_len = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_len_q.delete();
    acc_q.delete();
    run_len = 0;
    stable_err = 0;
    first_ready = -1;
    done_cyc = -1;
    max_addr = 0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_byte_ready"}, 32'(v_ready), 32'd0);
    chk({pfx, "_sram_addr"}, 32'(v_addr), 32'd0);
    chk({pfx, "_sram_wdata"}, 32'(v_wdata), 32'd0);
    chk({pfx, "_sram_we"}, 32'(v_we), 32'd0);
    chk({pfx, "_done"}, 32'(v_done), 32'd0);
    chk({pfx, "_words_written"}, 32'(v_ww), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; tb_load = 1'b0; tb_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic valid_for(input int mode, input int c);
    int ph;
    ph = c % 4;
    if (mode == 0) return 1'b1;
    if (mode == 1) return (ph == 0) || (ph == 3);
    return ($urandom_range(0, 3) != 0);
  endfunction

  // Pulse LOAD_MEM, then present src_q as a valid/ready stream. The source
  // holds each byte until it is taken and shows junk while valid is low.
  task automatic run_load(input int mode, input bit wait_done);
    int idx = 0;
    int cyc = 0;
    logic take;
    @(posedge clk); #1; tb_load = 1'b1;
    @(posedge clk); #1; tb_load = 1'b0;
    tb_valid = valid_for(mode, 0);
    tb_data = tb_valid ? src_q[0] : 8'($urandom);
    while (idx < src_q.size() && cyc < 500) begin
      @(negedge clk);
      take = tb_valid & v_ready;
      @(posedge clk); #1;
      if (take) idx++;
      cyc++;
      tb_valid = (idx < src_q.size()) ? valid_for(mode, cyc) : 1'b0;
      tb_data = (tb_valid && idx < src_q.size()) ? src_q[idx] : 8'($urandom);
    end
    chk("stream_consumed", 32'(idx), 32'(src_q.size()));
    if (wait_done) begin
      while (!v_done && cyc < 500) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("load_finished", 32'(v_done), 32'd1);
      @(negedge clk); #1;
    end
  endtask

  // Expected writes come straight from the bytes sent: word i is stored at
  // address i, with byte 2i in bits [7:0] and byte 2i+1 in bits [15:8].
  task automatic check_load(input int n, input int wc, input bit timed);
    chk("num_writes", 32'(wr_addr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      chk($sformatf("wr%0d_addr", i), 32'(wr_addr_q[i]), 32'(i));
      chk($sformatf("wr%0d_data", i), 32'(wr_data_q[i]),
          32'(int'(src_q[2*i]) + 256 * int'(src_q[2*i+1])));
      chk($sformatf("wr%0d_we_len", i), 32'(wr_len_q[i]), 32'(wc));
    end
    chk("addr_data_stable_in_write", 32'(stable_err), 32'd0);
    chk("bytes_accepted", 32'(acc_q.size()), 32'(2 * n));
    for (int i = 0; i < acc_q.size() && i < src_q.size(); i++)
      chk($sformatf("acc%0d", i), 32'(acc_q[i]), 32'(src_q[i]));
    chk("words_written", 32'(v_ww), 32'(n));
    chk("max_addr", 32'(max_addr), 32'(n - 1));
    if (timed) chk("done_latency", 32'(done_cyc - first_ready), 32'(n * (2 + wc)));
  endtask

  task automatic set_src_seq();
    src_q.delete();
    for (int i = 1; i <= 8; i++) src_q.push_back(8'(i * 17));
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_all_zero("reset");

    // Idle with no start: byte_valid held high, LOAD_MEM low
    tb_valid = 1'b1; tb_data = 8'h11;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("idle_byte_ready", 32'(v_ready), 32'd0);
      chk("idle_sram_we", 32'(v_we), 32'd0);
      chk("idle_sram_addr", 32'(v_addr), 32'd0);
    end

    // Basic load: 0x11..0x88 back-to-back
    clear_mon();
    set_src_seq();
    run_load(0, 1'b1);
    check_load(4, 2, 1'b1);
    $display("basic load: %0d writes, done after %0d cycles", wr_addr_q.size(), done_cyc - first_ready);

    // DONE is terminal
    tb_valid = 1'b1; tb_data = 8'h5A;
    @(posedge clk); #1; tb_load = 1'b1;
    @(posedge clk); #1; tb_load = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("term_done", 32'(v_done), 32'd1);
      chk("term_byte_ready", 32'(v_ready), 32'd0);
      chk("term_sram_we", 32'(v_we), 32'd0);
    end
    chk("term_num_writes", 32'(wr_addr_q.size()), 32'd4);
    chk("term_words_written", 32'(v_ww), 32'd4);
    $display("done terminal: done=%0b words_written=%0d", v_done, v_ww);

    // Throttled source: valid pattern 1,0,0,1
    do_reset();
    clear_mon();
    set_src_seq();
    run_load(1, 1'b1);
    check_load(4, 2, 1'b0);
    $display("throttled load: %0d writes, %0d bytes accepted", wr_addr_q.size(), acc_q.size());

    // Random bytes with a random valid pattern
    do_reset();
    clear_mon();
    src_q.delete();
    for (int i = 0; i < 8; i++) src_q.push_back(8'($urandom));
    run_load(2, 1'b1);
    check_load(4, 2, 1'b0);
    $display("random load: %0d writes, last data 0x%0h", wr_addr_q.size(), v_wdata);

    // Reset during the second WRITE cycle of word 1
    do_reset();
    clear_mon();
    src_q.delete();
    src_q.push_back(8'h11); src_q.push_back(8'h22);
    src_q.push_back(8'h33); src_q.push_back(8'h44);
    run_load(0, 1'b0);
    chk("mid_we_cycle1", 32'(v_we), 32'd1);
    chk("mid_addr_word1", 32'(v_addr), 32'd1);
    @(posedge clk); #1;
    chk("mid_we_cycle2", 32'(v_we), 32'd1);
    chk("mid_ww_before_reset", 32'(v_ww), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_all_zero("mid_reset");
    @(negedge clk); #1;
    clear_mon();
    set_src_seq();
    run_load(0, 1'b1);
    check_load(4, 2, 1'b1);
    $display("restart after reset: %0d writes, words_written=%0d", wr_addr_q.size(), v_ww);

    // Boundary: NUM_WORDS=1, WRITE_CYCLES=1
    sel = 1'b1;
    do_reset();
    chk_all_zero("b_reset");
    clear_mon();
    src_q.delete();
    src_q.push_back(8'hCD); src_q.push_back(8'hAB);
    run_load(0, 1'b1);
    check_load(1, 1, 1'b1);
    chk("b_addr_final", 32'(v_addr), 32'd0);
    $display("boundary load: %0d writes, data 0x%0h", wr_addr_q.size(), v_wdata);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
